// File: rtl/computational_unit.sv
`default_nettype none
// ============================================================================
// Module   : computational_unit
// Purpose  : 4-bit datapath with register file, data memory and ALU.
// Revision : 1.0
// ============================================================================
module computational_unit #(
    parameter int DATA_WIDTH = 4,
    parameter int DM_DEPTH   = 16
) (
    input  logic                  clk,
    input  logic                  sync_reset,
    input  logic [7:0]            ir,
    input  logic [DATA_WIDTH-1:0] ir_nibble,
    input  logic [DATA_WIDTH-1:0] i_pins,
    input  logic [8:0]            reg_en,
    input  logic [3:0]            source_sel,
    input  logic                  x_sel,
    input  logic                  y_sel,
    input  logic                  i_sel,
    input  logic                  NOPC8,
    input  logic                  NOPCF,
    input  logic                  NOPD8,
    input  logic                  NOPDF,
    output logic [DATA_WIDTH-1:0] data_bus,
    output logic [DATA_WIDTH-1:0] o_reg,
    output logic                  dont_jmp,
    output logic [DATA_WIDTH-1:0] x0,
    output logic [DATA_WIDTH-1:0] x1,
    output logic [DATA_WIDTH-1:0] y0,
    output logic [DATA_WIDTH-1:0] y1,
    output logic [DATA_WIDTH-1:0] r,
    output logic [DATA_WIDTH-1:0] m,
    output logic [DATA_WIDTH-1:0] i
);

    localparam logic [DATA_WIDTH-1:0] c_ZERO = '0;

    logic [DATA_WIDTH-1:0]   r_x0, r_x1, r_y0, r_y1, r_r, r_m, r_i, r_o_reg;
    logic                    r_dont_jmp;
    logic [DATA_WIDTH-1:0]   r_dm [DM_DEPTH];

    logic [DATA_WIDTH-1:0]   w_bus;
    logic [DATA_WIDTH-1:0]   w_x, w_y, w_alu;
    logic [2*DATA_WIDTH-1:0] w_prod;
    logic                    w_nop;
    logic                    w_unused_ir;

    // Only the function field of the instruction is used here.
    assign w_unused_ir = ^ir[7:3];

    always_comb begin
        w_bus = c_ZERO;
        case (source_sel)
            4'd0:    w_bus = r_x0;
            4'd1:    w_bus = r_x1;
            4'd2:    w_bus = r_y0;
            4'd3:    w_bus = r_y1;
            4'd4:    w_bus = r_r;
            4'd5:    w_bus = r_m;
            4'd6:    w_bus = r_i;
            4'd7:    w_bus = r_dm[r_i];
            4'd8:    w_bus = ir_nibble;
            4'd9:    w_bus = i_pins;
            default: w_bus = c_ZERO;
        endcase
    end

    assign w_x    = x_sel ? r_x1 : r_x0;
    assign w_y    = y_sel ? r_y1 : r_y0;
    assign w_prod = {c_ZERO, w_x} * {c_ZERO, w_y};
    assign w_nop  = NOPC8 | NOPCF | NOPD8 | NOPDF;

    always_comb begin
        w_alu = c_ZERO;
        case (ir[2:0])
            3'b000:  w_alu = c_ZERO - w_x;
            3'b001:  w_alu = w_x - w_y;
            3'b010:  w_alu = w_x + w_y;
            3'b011:  w_alu = w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
            3'b100:  w_alu = w_prod[DATA_WIDTH-1:0];
            3'b101:  w_alu = w_x ^ w_y;
            3'b110:  w_alu = w_x & w_y;
            default: w_alu = ~w_x;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_x0       <= c_ZERO;
            r_x1       <= c_ZERO;
            r_y0       <= c_ZERO;
            r_y1       <= c_ZERO;
            r_r        <= c_ZERO;
            r_m        <= c_ZERO;
            r_i        <= c_ZERO;
            r_o_reg    <= c_ZERO;
            r_dont_jmp <= 1'b1;
        end else begin
            if (reg_en[0]) r_x0    <= w_bus;
            if (reg_en[1]) r_x1    <= w_bus;
            if (reg_en[2]) r_y0    <= w_bus;
            if (reg_en[3]) r_y1    <= w_bus;
            if (reg_en[5]) r_m     <= w_bus;
            if (reg_en[8]) r_o_reg <= w_bus;
            if (reg_en[6]) r_i     <= i_sel ? (r_i + r_m) : w_bus;
            // A no-op suppresses both r and the zero flag.
            if (reg_en[4] && !w_nop) begin
                r_r        <= w_alu;
                r_dont_jmp <= (w_alu == c_ZERO);
            end
        end
    end

    // Memory is not cleared, but reset still cancels a pending write.
    always_ff @(posedge clk) begin
        if (!sync_reset && reg_en[7])
            r_dm[r_i] <= w_bus;
    end

    assign data_bus = w_bus;
    assign o_reg    = r_o_reg;
    assign dont_jmp = r_dont_jmp;
    assign x0       = r_x0;
    assign x1       = r_x1;
    assign y0       = r_y0;
    assign y1       = r_y1;
    assign r        = r_r;
    assign m        = r_m;
    assign i        = r_i;

endmodule
`default_nettype wire

// File: tb/tb_computational_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_computational_unit
// Purpose  : Vector table and scoreboard bench for computational_unit.
// Revision : 1.0
// ============================================================================
module tb_computational_unit;

    localparam int c_X0 = 0, c_X1 = 1, c_Y0 = 2, c_Y1 = 3, c_R = 4,
                   c_M = 5, c_I = 6, c_O = 7, c_BUS = 8;

    typedef struct {
        logic [3:0] src;
        logic [8:0] en;
        logic       xs, ys, isel;
        logic [3:0] nop;
        logic [7:0] ir;
        logic [3:0] nib, pins;
        int         tgt;
        logic [3:0] exp;
        logic       dj;
    } vec_t;

    typedef struct {
        int         tgt;
        logic [3:0] exp;
        logic       dj;
    } exp_t;

    logic       clk = 1'b0;
    logic       sync_reset;
    logic [7:0] ir;
    logic [3:0] ir_nibble, i_pins, source_sel;
    logic [8:0] reg_en;
    logic       x_sel, y_sel, i_sel;
    logic       NOPC8, NOPCF, NOPD8, NOPDF;
    logic [3:0] data_bus, o_reg, x0, x1, y0, y1, r, m, i;
    logic       dont_jmp;

    int total = 0;
    int bad   = 0;
    vec_t tbl[$];
    exp_t exp_q[$];

    computational_unit dut (
        .clk(clk), .sync_reset(sync_reset), .ir(ir), .ir_nibble(ir_nibble),
        .i_pins(i_pins), .reg_en(reg_en), .source_sel(source_sel),
        .x_sel(x_sel), .y_sel(y_sel), .i_sel(i_sel),
        .NOPC8(NOPC8), .NOPCF(NOPCF), .NOPD8(NOPD8), .NOPDF(NOPDF),
        .data_bus(data_bus), .o_reg(o_reg), .dont_jmp(dont_jmp),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1), .r(r), .m(m), .i(i)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] src, input logic [8:0] en,
                                input logic xs, input logic ys, input logic isel,
                                input logic [3:0] nop, input logic [7:0] irv,
                                input logic [3:0] nib, input logic [3:0] pins,
                                input int tgt, input logic [3:0] exp, input logic dj);
        vec_t v;
        v.src = src; v.en = en; v.xs = xs; v.ys = ys; v.isel = isel;
        v.nop = nop; v.ir = irv; v.nib = nib; v.pins = pins;
        v.tgt = tgt; v.exp = exp; v.dj = dj;
        return v;
    endfunction

    function automatic logic [3:0] tap(input int tgt);
        case (tgt)
            c_X0:    return x0;
            c_X1:    return x1;
            c_Y0:    return y0;
            c_Y1:    return y1;
            c_R:     return r;
            c_M:     return m;
            c_I:     return i;
            c_O:     return o_reg;
            default: return data_bus;
        endcase
    endfunction

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        source_sel = v.src; reg_en = v.en; x_sel = v.xs; y_sel = v.ys;
        i_sel = v.isel; {NOPDF, NOPD8, NOPCF, NOPC8} = v.nop; ir = v.ir;
        ir_nibble = v.nib; i_pins = v.pins;
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        drive(v);
        exp_q.push_back('{tgt: v.tgt, exp: v.exp, dj: v.dj});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check4($sformatf("vec%0d_tgt%0d", idx, e.tgt), tap(e.tgt), e.exp);
        check4($sformatf("vec%0d_dont_jmp", idx), {3'b0, dont_jmp}, {3'b0, e.dj});
    endtask

    initial begin
        drive(mk(4'd10, 9'h1FF, 0, 0, 0, 4'h0, 8'h00, 4'h0, 4'h0, c_X0, 4'h0, 1'b1));
        sync_reset = 1'b1;

        // Loads, ALU functions, zero flag.
        tbl.push_back(mk(4'd8,  9'h001, 0, 0, 0, 4'h0, 8'h00, 4'h5, 4'h0, c_X0, 4'h5, 1'b1));
        tbl.push_back(mk(4'd8,  9'h004, 0, 0, 0, 4'h0, 8'h00, 4'h3, 4'h0, c_Y0, 4'h3, 1'b1));
        tbl.push_back(mk(4'd0,  9'h010, 0, 0, 0, 4'h0, 8'h02, 4'h0, 4'h0, c_R,  4'h8, 1'b0));
        tbl.push_back(mk(4'd0,  9'h010, 0, 0, 0, 4'h0, 8'h01, 4'h0, 4'h0, c_R,  4'h2, 1'b0));
        tbl.push_back(mk(4'd8,  9'h002, 0, 0, 0, 4'h0, 8'h00, 4'h3, 4'h0, c_X1, 4'h3, 1'b0));
        tbl.push_back(mk(4'd8,  9'h008, 0, 0, 0, 4'h0, 8'h00, 4'h5, 4'h0, c_Y1, 4'h5, 1'b0));
        tbl.push_back(mk(4'd0,  9'h010, 1, 1, 0, 4'h0, 8'h01, 4'h0, 4'h0, c_R,  4'hE, 1'b0));
        tbl.push_back(mk(4'd0,  9'h010, 0, 0, 0, 4'h0, 8'h00, 4'h0, 4'h0, c_R,  4'hB, 1'b0));
        tbl.push_back(mk(4'd0,  9'h010, 0, 0, 0, 4'h0, 8'h05, 4'h0, 4'h0, c_R,  4'h6, 1'b0));
        tbl.push_back(mk(4'd0,  9'h010, 0, 0, 0, 4'h0, 8'h06, 4'h0, 4'h0, c_R,  4'h1, 1'b0));
        tbl.push_back(mk(4'd0,  9'h010, 0, 0, 0, 4'h0, 8'h07, 4'h0, 4'h0, c_R,  4'hA, 1'b0));
        tbl.push_back(mk(4'd8,  9'h002, 0, 0, 0, 4'h0, 8'h00, 4'hF, 4'h0, c_X1, 4'hF, 1'b0));
        tbl.push_back(mk(4'd8,  9'h008, 0, 0, 0, 4'h0, 8'h00, 4'hF, 4'h0, c_Y1, 4'hF, 1'b0));
        tbl.push_back(mk(4'd0,  9'h010, 1, 1, 0, 4'h0, 8'h03, 4'h0, 4'h0, c_R,  4'hE, 1'b0));
        tbl.push_back(mk(4'd0,  9'h010, 1, 1, 0, 4'h0, 8'h04, 4'h0, 4'h0, c_R,  4'h1, 1'b0));
        tbl.push_back(mk(4'd10, 9'h001, 0, 0, 0, 4'h0, 8'h00, 4'h0, 4'h0, c_X0, 4'h0, 1'b0));
        tbl.push_back(mk(4'd15, 9'h004, 0, 0, 0, 4'h0, 8'h00, 4'h7, 4'h0, c_Y0, 4'h0, 1'b0));
        tbl.push_back(mk(4'd0,  9'h010, 0, 0, 0, 4'h0, 8'h02, 4'h0, 4'h0, c_R,  4'h0, 1'b1));
        // No-op flags hold r and the zero flag.
        tbl.push_back(mk(4'd8,  9'h001, 0, 0, 0, 4'h0, 8'h00, 4'h5, 4'h0, c_X0, 4'h5, 1'b1));
        tbl.push_back(mk(4'd8,  9'h004, 0, 0, 0, 4'h0, 8'h00, 4'h3, 4'h0, c_Y0, 4'h3, 1'b1));
        tbl.push_back(mk(4'd0,  9'h010, 0, 0, 0, 4'h0, 8'h02, 4'h0, 4'h0, c_R,  4'h8, 1'b0));
        tbl.push_back(mk(4'd0,  9'h010, 0, 0, 0, 4'h1, 8'hC8, 4'h0, 4'h0, c_R,  4'h8, 1'b0));
        tbl.push_back(mk(4'd0,  9'h010, 0, 0, 0, 4'h2, 8'hCF, 4'h0, 4'h0, c_R,  4'h8, 1'b0));
        tbl.push_back(mk(4'd0,  9'h010, 0, 0, 0, 4'h4, 8'hD8, 4'h0, 4'h0, c_R,  4'h8, 1'b0));
        tbl.push_back(mk(4'd0,  9'h010, 0, 0, 0, 4'h8, 8'hDF, 4'h0, 4'h0, c_R,  4'h8, 1'b0));
        // Data memory with post-increment addressing.
        tbl.push_back(mk(4'd8,  9'h020, 0, 0, 0, 4'h0, 8'h00, 4'h1, 4'h0, c_M,  4'h1, 1'b0));
        tbl.push_back(mk(4'd8,  9'h040, 0, 0, 0, 4'h0, 8'h00, 4'h2, 4'h0, c_I,  4'h2, 1'b0));
        tbl.push_back(mk(4'd8,  9'h001, 0, 0, 0, 4'h0, 8'h00, 4'hA, 4'h0, c_X0, 4'hA, 1'b0));
        tbl.push_back(mk(4'd0,  9'h0C0, 0, 0, 1, 4'h0, 8'h00, 4'h0, 4'h0, c_I,  4'h3, 1'b0));
        tbl.push_back(mk(4'd8,  9'h040, 0, 0, 0, 4'h0, 8'h00, 4'h2, 4'h0, c_I,  4'h2, 1'b0));
        tbl.push_back(mk(4'd7,  9'h042, 0, 0, 1, 4'h0, 8'h00, 4'h0, 4'h0, c_X1, 4'hA, 1'b0));
        tbl.push_back(mk(4'd0,  9'h000, 0, 0, 0, 4'h0, 8'h00, 4'h0, 4'h0, c_I,  4'h3, 1'b0));
        tbl.push_back(mk(4'd8,  9'h020, 0, 0, 0, 4'h0, 8'h00, 4'hF, 4'h0, c_M,  4'hF, 1'b0));
        tbl.push_back(mk(4'd10, 9'h040, 0, 0, 0, 4'h0, 8'h00, 4'h0, 4'h0, c_I,  4'h0, 1'b0));
        tbl.push_back(mk(4'd0,  9'h040, 0, 0, 1, 4'h0, 8'h00, 4'h0, 4'h0, c_I,  4'hF, 1'b0));
        // Pins, output port, multi-destination write.
        tbl.push_back(mk(4'd9,  9'h008, 0, 0, 0, 4'h0, 8'h00, 4'h0, 4'h6, c_Y1, 4'h6, 1'b0));
        tbl.push_back(mk(4'd8,  9'h001, 0, 0, 0, 4'h0, 8'h00, 4'h5, 4'h0, c_X0, 4'h5, 1'b0));
        tbl.push_back(mk(4'd0,  9'h010, 0, 0, 0, 4'h0, 8'h02, 4'h0, 4'h0, c_R,  4'h8, 1'b0));
        tbl.push_back(mk(4'd4,  9'h100, 0, 0, 0, 4'h0, 8'h00, 4'h0, 4'h0, c_O,  4'h8, 1'b0));
        tbl.push_back(mk(4'd8,  9'h003, 0, 0, 0, 4'h0, 8'h00, 4'h9, 4'h0, c_X0, 4'h9, 1'b0));
        tbl.push_back(mk(4'd0,  9'h000, 0, 0, 0, 4'h0, 8'h00, 4'h0, 4'h0, c_X1, 4'h9, 1'b0));

        repeat (2) @(posedge clk);
        #1;
        check4("rst_x0", x0, 4'h0);   check4("rst_x1", x1, 4'h0);
        check4("rst_y0", y0, 4'h0);   check4("rst_y1", y1, 4'h0);
        check4("rst_r",  r,  4'h0);   check4("rst_m",  m,  4'h0);
        check4("rst_i",  i,  4'h0);   check4("rst_o",  o_reg, 4'h0);
        check4("rst_dont_jmp", {3'b0, dont_jmp}, 4'h1);
        sync_reset = 1'b0;

        for (int k = 0; k < tbl.size(); k++)
            apply(tbl[k], k);

        // Reset during a memory write must leave dm[2] intact.
        drive(mk(4'd8, 9'h040, 0, 0, 0, 4'h0, 8'h00, 4'h2, 4'h0, c_I, 4'h2, 1'b0));
        @(posedge clk);
        #1;
        source_sel = 4'd7; reg_en = 9'h000;
        #1;
        check4("dm2_before_reset", data_bus, 4'hA);
        sync_reset = 1'b1;
        drive(mk(4'd8, 9'h080, 0, 0, 0, 4'h0, 8'h00, 4'h7, 4'h0, c_I, 4'h0, 1'b1));
        @(posedge clk);
        #1;
        sync_reset = 1'b0;
        check4("rst_mid_i", i, 4'h0);
        check4("rst_mid_x0", x0, 4'h0);
        check4("rst_mid_dont_jmp", {3'b0, dont_jmp}, 4'h1);
        drive(mk(4'd8, 9'h040, 0, 0, 0, 4'h0, 8'h00, 4'h2, 4'h0, c_I, 4'h2, 1'b1));
        @(posedge clk);
        #1;
        source_sel = 4'd7; reg_en = 9'h000;
        #1;
        check4("dm2_after_reset", data_bus, 4'hA);
        source_sel = 4'd12;
        #1;
        check4("bus_zero_src12", data_bus, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
